vga_frame_reader: RTL

Parametrised VGA scan engine for the display path. It generates the VGA timing counters and hsync/vsync/blank signals, and computes the framebuffer read address for a placed, optionally 2x-scaled image window. It fetches pixels from a synchronous pixel memory with configurable read latency and outputs sync and pixel data aligned. It replaces the free-running 16-bit pixel-address counter and widens it to full 640x480 raster timing, window placement, scaling and border fill.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_frame_reader_if.sv | 14 +
 rtl/vga_timing_gen.sv | 59 +++++
 rtl/vga_frame_reader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path.
// Holds the default 640x480@60 timing, the counter widths derived from the
// default line/frame totals, and the record carried down the fetch-latency
// delay line.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Bits needed to count 0..total-1; never less than one bit.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  // 800 and 525 both need 10 bits; smaller timings reuse the same width.
  localparam int H_CNT_W = cnt_width(H_TOTAL_DEF);
  localparam int V_CNT_W = cnt_width(V_TOTAL_DEF);

  typedef logic [H_CNT_W-1:0] hcnt_t;
  typedef logic [V_CNT_W-1:0] vcnt_t;

  // One raster position's worth of timing state, travelling alongside the
  // memory read so that it meets the returned pixel.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic win;
  } sync_t;

  // Value of a delay-line stage that carries no raster position yet.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, win: 1'b0};

endpackage

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port.
//   mem_addr : read address, driven by the frame reader
//   mem_data : read data, driven by the pixel memory
// master = frame reader side, slave = memory side.
interface vga_frame_reader_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator.
//   vga_clk, reset : pixel clock, synchronous active-high reset
//   h, v           : current raster position (stage 0)
//   hsync_raw      : active-low horizontal sync for the current position
//   vsync_raw      : active-low vertical sync for the current position
//   active         : current position lies in the visible area
//   frame_start    : high while the position is h=0,v=0 (not during reset)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic  vga_clk,
  input  logic  reset,
  output hcnt_t h,
  output vcnt_t v,
  output logic  hsync_raw,
  output logic  vsync_raw,
  output logic  active,
  output logic  frame_start
);

  localparam hcnt_t H_LAST   = hcnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam vcnt_t V_LAST   = vcnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam hcnt_t H_VIS    = hcnt_t'(H_ACTIVE);
  localparam vcnt_t V_VIS    = vcnt_t'(V_ACTIVE);
  localparam hcnt_t HS_START = hcnt_t'(H_ACTIVE + H_FP);
  localparam hcnt_t HS_END   = hcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t VS_START = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t VS_END   = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

  // Pixel counter wraps at the end of each line and steps the line counter;
  // the line counter wraps at the end of the frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign hsync_raw   = !((h >= HS_START) && (h < HS_END));
  assign vsync_raw   = !((v >= VS_START) && (v < VS_END));
  assign active      = (h < H_VIS) && (v < V_VIS);
  // Gated by reset so a held reset does not read as a stream of frame starts.
  assign frame_start = !reset && (h == '0) && (v == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan engine with a placed, optionally 2x-scaled framebuffer window.
//   vga_clk, reset : pixel clock, synchronous active-high reset
//   enable         : display enable; 0 blanks pixel data and parks mem_addr at 0
//   scale2x        : 0 = 1x, 1 = pixel/line doubling
//   x_off, y_off   : window top-left corner in active pixels/lines
//   border_color   : colour for the active area outside the window
//   mem            : framebuffer read port (master side). mem_data must carry
//                    the word for the mem_addr launched MEM_LAT clock edges
//                    earlier, the edge that loads mem_addr counting as the first.
//   pixel, hsync, vsync, blank_n : display outputs, MEM_LAT+1 cycles behind
//                    the raster counters; syncs are active-low
//   frame_start    : one-cycle pulse at h=0,v=0, counter-aligned
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 16,
  parameter int PIX_W    = 8,
  parameter int MEM_LAT  = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              scale2x,
  input  logic [9:0]        x_off,
  input  logic [9:0]        y_off,
  input  logic [PIX_W-1:0]  border_color,
  vga_frame_reader_if.master mem,
  output logic [PIX_W-1:0]  pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_start
);

  // Image width is a power of two, so the address is {row, column}.
  localparam int XW = $clog2(IMG_W);
  localparam int YW = ADDR_W - XW;

  hcnt_t h;
  vcnt_t v;
  logic  hsync_raw, vsync_raw, active;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .h          (h),
    .v          (v),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .active     (active),
    .frame_start(frame_start)
  );

  logic       at_origin;
  logic       scale_sh, scale_eff;
  logic [9:0] x_sh, y_sh, x_eff, y_eff;

  assign at_origin = (h == '0) && (v == '0);

  // Placement settings are frozen for a whole frame. They are latched at the
  // frame origin (and during reset); the origin pixel itself already uses the
  // live inputs so the new settings cover the complete frame.
  always_ff @(posedge vga_clk) begin
    if (reset || at_origin) begin
      scale_sh <= scale2x;
      x_sh     <= x_off;
      y_sh     <= y_off;
    end
  end

  assign scale_eff = at_origin ? scale2x : scale_sh;
  assign x_eff     = at_origin ? x_off   : x_sh;
  assign y_eff     = at_origin ? y_off   : y_sh;

  logic [10:0]       dx, dy, win_w, win_h;
  logic              in_win;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic [ADDR_W-1:0] addr;
  sync_t             stage0;

  // The >= guard runs first, so the 11-bit differences are never a wrapped
  // negative value when they reach the size compare.
  assign dx     = {1'b0, h} - {1'b0, x_eff};
  assign dy     = {1'b0, v} - {1'b0, y_eff};
  assign win_w  = scale_eff ? 11'(IMG_W * 2) : 11'(IMG_W);
  assign win_h  = scale_eff ? 11'(IMG_H * 2) : 11'(IMG_H);
  assign in_win = active && (h >= x_eff) && (dx < win_w)
                         && (v >= y_eff) && (dy < win_h);

  // In 2x mode each source pixel and line is used twice, so drop the LSB.
  assign col    = scale_eff ? dx[XW:1] : dx[XW-1:0];
  assign row    = scale_eff ? dy[YW:1] : dy[YW-1:0];
  assign addr   = {row, col};
  assign stage0 = '{hs: hsync_raw, vs: vsync_raw, act: active, win: in_win};

  // Read address register; parked at 0 whenever no fetch is wanted.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      mem.mem_addr <= '0;
    end else begin
      mem.mem_addr <= (enable && in_win) ? addr : '0;
    end
  end

  sync_t [MEM_LAT-1:0] dl;
  logic  [MEM_LAT-1:0] en_dl;

  // Timing state rides a MEM_LAT-deep shift register to meet mem_data.
  // The enable that launched each fetch rides along too, so that data fetched
  // while the display was disabled (address 0) is never shown.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) dl[i] <= SYNC_IDLE;
      en_dl <= '0;
    end else begin
      dl[0]    <= stage0;
      en_dl[0] <= enable;
      for (int i = 1; i < MEM_LAT; i++) begin
        dl[i]    <= dl[i-1];
        en_dl[i] <= en_dl[i-1];
      end
    end
  end

  sync_t            tail;
  logic             en_tail;
  logic [PIX_W-1:0] pixel_next;

  assign tail    = dl[MEM_LAT-1];
  assign en_tail = en_dl[MEM_LAT-1];

  // Output colour: black outside the active area or while disabled (live
  // enable, so blanking is immediate), border around the window, memory
  // data inside it.
  always_comb begin
    pixel_next = '0;
    if (tail.act && enable) begin
      if (!tail.win)    pixel_next = border_color;
      else if (en_tail) pixel_next = mem.mem_data;
    end
  end

  // Final output register keeps pixel and syncs on the same cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pixel   <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
    end else begin
      pixel   <= pixel_next;
      hsync   <= tail.hs;
      vsync   <= tail.vs;
      blank_n <= tail.act;
    end
  end

endmodule
